// File: rtl/lsu_mem_adapter_if.sv
// Bundles the core request/response handshake and the data-memory port
// of the load/store unit. The adapter uses the slave view; the core and
// memory side (or a testbench) use the master view.
interface lsu_mem_adapter_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Load/store unit adapter: turns RV32I byte/half/word loads and stores
// into word accesses on a memory with combinational read and synchronous
// word write. Sub-word stores are done as read-modify-write. Misaligned,
// illegal-funct3 and out-of-range requests complete with resp_err.
// Optional feature macro: LSU_PERF_CNT_EN adds saturating 16-bit response
// counters perf_loads / perf_stores / perf_errors.
module lsu_mem_adapter #(
  parameter int MEM_WORDS = 64,
  parameter int ADDR_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  lsu_mem_adapter_if.slave bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
  output logic [15:0] perf_errors
`endif
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_RD   = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4,
    ERR_DONE = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              lat_we_r;
  logic [2:0]        lat_funct3_r;
  logic [ADDR_W-1:0] lat_addr_r;
  logic [31:0]       lat_wdata_r;
  logic [31:0]       merge_r;
  logic [31:0]       resp_rdata_r;
  logic              accept_s;
  logic              err_s;
  logic              req_ready_s;
  logic              resp_valid_s;
  logic              resp_err_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_wdata_s;

  // Request legality: funct3 encoding, natural alignment, memory bounds.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [ADDR_W-1:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      illegal = (f3 > 3'd2);
    end else begin
      illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    misaligned   = ((f3[1:0] == 2'd1) && addr[0]) ||
                   ((f3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[ADDR_W-1:2]} >= MEM_LIMIT);
    return illegal || misaligned || out_of_range;
  endfunction

  // Selects the addressed lane of a memory word and extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = word;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replaces the addressed byte/half of a memory word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (f3[1:0] == 2'd0) begin
      case (off)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        2'd3:    r[31:24] = wdata[7:0];
        default: r = word;
      endcase
    end else if (off[1]) begin
      r[31:16] = wdata[15:0];
    end else begin
      r[15:0] = wdata[15:0];
    end
    return r;
  endfunction

  assign accept_s = bus.req_valid && (state_r == IDLE);
  assign err_s    = req_error(bus.req_we, bus.req_funct3, bus.req_addr);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the error check picks the path out of IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (err_s) begin
          state_nxt_s = ERR_DONE;
        end else if (!bus.req_we) begin
          state_nxt_s = LOAD;
        end else if (bus.req_funct3 == 3'd2) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = RMW_RD;
        end
      end
      LOAD:     state_nxt_s = DONE;
      RMW_RD:   state_nxt_s = WRITE;
      WRITE:    state_nxt_s = DONE;
      DONE:     state_nxt_s = IDLE;
      ERR_DONE: state_nxt_s = IDLE;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Handshake and memory-port outputs decoded from the state register, so
  // an asynchronous reset drops mem_we without waiting for a clock edge.
  always_comb begin
    req_ready_s  = (state_r == IDLE);
    resp_valid_s = (state_r == DONE) || (state_r == ERR_DONE);
    resp_err_s   = (state_r == ERR_DONE);
    mem_we_s     = (state_r == WRITE);
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_wdata_s  = 32'd0;
    if (state_r != IDLE) begin
      mem_addr_s = {lat_addr_r[ADDR_W-1:2], 2'b00};
    end else begin
      mem_addr_s = {ADDR_W{1'b0}};
    end
    if (state_r == WRITE) begin
      mem_wdata_s = (lat_funct3_r[1:0] == 2'd2) ? lat_wdata_r : merge_r;
    end else begin
      mem_wdata_s = 32'd0;
    end
  end

  // Request latches, merge buffer and load-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we_r     <= 1'b0;
      lat_funct3_r <= 3'd0;
      lat_addr_r   <= {ADDR_W{1'b0}};
      lat_wdata_r  <= 32'd0;
      merge_r      <= 32'd0;
      resp_rdata_r <= 32'd0;
    end else begin
      if (accept_s) begin
        lat_we_r     <= bus.req_we;
        lat_funct3_r <= bus.req_funct3;
        lat_addr_r   <= bus.req_addr;
        lat_wdata_r  <= bus.req_wdata;
        if (err_s) begin
          resp_rdata_r <= 32'd0;
        end
      end
      case (state_r)
        LOAD:    resp_rdata_r <= load_extract(bus.mem_rdata, lat_funct3_r, lat_addr_r[1:0]);
        RMW_RD:  merge_r <= merge_lane(bus.mem_rdata, lat_wdata_r, lat_funct3_r, lat_addr_r[1:0]);
        WRITE:   resp_rdata_r <= 32'd0;
        default: merge_r <= merge_r;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_err   = resp_err_s;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;

`ifdef LSU_PERF_CNT_EN
  logic [15:0] perf_loads_r;
  logic [15:0] perf_stores_r;
  logic [15:0] perf_errors_r;

  // Saturating response counters, bumped on the completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads_r  <= 16'd0;
      perf_stores_r <= 16'd0;
      perf_errors_r <= 16'd0;
    end else begin
      if ((state_r == DONE) && !lat_we_r && (perf_loads_r != 16'hFFFF)) begin
        perf_loads_r <= perf_loads_r + 16'd1;
      end
      if ((state_r == DONE) && lat_we_r && (perf_stores_r != 16'hFFFF)) begin
        perf_stores_r <= perf_stores_r + 16'd1;
      end
      if ((state_r == ERR_DONE) && (perf_errors_r != 16'hFFFF)) begin
        perf_errors_r <= perf_errors_r + 16'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_r;
  assign perf_stores = perf_stores_r;
  assign perf_errors = perf_errors_r;
`endif

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: directed cases followed by
// randomized requests checked against a behavioural memory/response model.
module tb_lsu_mem_adapter;
  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_adapter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef LSU_PERF_CNT_EN
  logic [15:0] perf_loads, perf_stores, perf_errors;
`endif

  lsu_mem_adapter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_errors (perf_errors)
`endif
  );

  // Data memory: combinational read, synchronous word write, backdoor preload.
  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        pl_en   = 1'b0;
  logic [5:0]  pl_idx  = 6'd0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk) begin
    if (bus.mem_we && (bus.mem_addr[31:8] == 24'd0)) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end
  assign bus.mem_rdata = (bus.mem_addr[31:8] == 24'd0) ? mem[bus.mem_addr[7:2]] : 32'd0;

  int n_pass   = 0;
  int n_checks = 0;
  int m_loads  = 0;
  int m_stores = 0;
  int m_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !legal || ((a % 32'(acc_size(f3))) != 32'd0) || ((a / 32'd4) >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input int off);
    logic [31:0] v;
    if (acc_size(f3) == 1) begin
      v = (word >> (8 * off)) & 32'h0000_00FF;
      if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (acc_size(f3) == 2) begin
      v = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input int off);
    logic [31:0] m;
    int sz;
    sz = acc_size(f3);
    if (sz == 4) m = 32'hFFFF_FFFF;
    else         m = ((32'd1 << (8 * sz)) - 32'd1) << (8 * off);
    return (old & ~m) | ((wd << (8 * off)) & m);
  endfunction

  task automatic preload(input int idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = 6'(idx);
    pl_data = data;
    ref_mem[idx] = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request: issue, wait (bounded) for the response, compare with the model.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic        e_err, got, a_err, rdy_busy;
    logic [31:0] e_rd, a_rd;
    int          e_lat, e_mw, lat, mw, idx;
    idx   = int'(addr / 32'd4);
    e_err = model_err(we, f3, addr);
    if (e_err)                      begin e_lat = 1; e_mw = 0; e_rd = 32'd0; end
    else if (!we)                   begin e_lat = 2; e_mw = 0; e_rd = model_load(ref_mem[idx], f3, int'(addr % 4)); end
    else if (acc_size(f3) == 4)     begin e_lat = 2; e_mw = 1; e_rd = 32'd0; end
    else                            begin e_lat = 3; e_mw = 1; e_rd = 32'd0; end
    if (!e_err && we) ref_mem[idx] = model_store(ref_mem[idx], wd, f3, int'(addr % 4));
    if (e_err) m_errs++; else if (we) m_stores++; else m_loads++;

    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0; mw = 0; got = 1'b0; a_rd = 32'd0; a_err = 1'b0; rdy_busy = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_we) mw++;
      if (bus.req_ready) rdy_busy = 1'b1;
      if (bus.resp_valid) begin
        got = 1'b1; lat = c; a_rd = bus.resp_rdata; a_err = bus.resp_err;
      end
      @(posedge clk); #1;
    end
    check_val({tag, " resp_seen"}, 32'(got), 32'd1);
    check_val({tag, " latency"}, 32'(lat), 32'(e_lat));
    check_val({tag, " err"}, 32'(a_err), 32'(e_err));
    check_val({tag, " rdata"}, a_rd, e_rd);
    check_val({tag, " mem_we_cycles"}, 32'(mw), 32'(e_mw));
    check_val({tag, " ready_busy"}, 32'(rdy_busy), 32'd0);
    check_val({tag, " ready_idle"}, 32'(bus.req_ready), 32'd1);
    check_val({tag, " valid_idle"}, 32'(bus.resp_valid), 32'd0);
    check_val({tag, " rdata_hold"}, bus.resp_rdata, e_rd);
    if (idx < MEM_WORDS) check_val({tag, " mem_word"}, mem[idx], ref_mem[idx]);
  endtask

  logic        bb_rdy [1:5];
  logic        bb_rv  [1:5];
  logic [31:0] bb_rd  [1:5];
  logic        w;
  logic [2:0]  f;
  logic [31:0] a;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
    preload(4, 32'h8899_AABB);
    @(negedge clk);
    check_val("rst req_ready", 32'(bus.req_ready), 32'd1);
    check_val("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst resp_err", 32'(bus.resp_err), 32'd0);
    check_val("rst resp_rdata", bus.resp_rdata, 32'd0);
    check_val("rst mem_we", 32'(bus.mem_we), 32'd0);
    check_val("rst mem_addr", bus.mem_addr, 32'd0);
    check_val("rst mem_wdata", bus.mem_wdata, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("LB 0x13",  1'b0, 3'd0, 32'h13, 32'd0);
    run_op("LBU 0x13", 1'b0, 3'd4, 32'h13, 32'd0);
    run_op("LH 0x12",  1'b0, 3'd1, 32'h12, 32'd0);
    run_op("LHU 0x10", 1'b0, 3'd5, 32'h10, 32'd0);
    run_op("LW 0x10",  1'b0, 3'd2, 32'h10, 32'd0);
    run_op("SB 0x11",  1'b1, 3'd0, 32'h11, 32'h1234_56CC);
    check_val("sb word", mem[4], 32'h8899_CCBB);
    run_op("SH 0x13 misaligned", 1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF);
    run_op("load f3=3", 1'b0, 3'd3, 32'h10, 32'd0);
    run_op("SW 0x100 oor", 1'b1, 3'd2, 32'h100, 32'hFFFF_FFFF);
    check_val("err word", mem[4], 32'h8899_CCBB);

    // Back-to-back: request held valid, second accepted only after DONE.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h20;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bb_rdy[c] = bus.req_ready; bb_rv[c] = bus.resp_valid; bb_rd[c] = bus.resp_rdata;
      @(posedge clk); #1;
      if (c == 3) bus.req_valid = 1'b0;
    end
    ref_mem[8] = 32'hDEAD_BEEF;
    m_stores++; m_loads++;
    check_val("b2b ready c1", 32'(bb_rdy[1]), 32'd0);
    check_val("b2b ready c2", 32'(bb_rdy[2]), 32'd0);
    check_val("b2b sw valid", 32'(bb_rv[2]), 32'd1);
    check_val("b2b ready idle", 32'(bb_rdy[3]), 32'd1);
    check_val("b2b ready load", 32'(bb_rdy[4]), 32'd0);
    check_val("b2b lw early", 32'(bb_rv[4]), 32'd0);
    check_val("b2b lw valid", 32'(bb_rv[5]), 32'd1);
    check_val("b2b lw rdata", bb_rd[5], 32'hDEAD_BEEF);
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom);
      f = 3'($urandom);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = (32'($urandom_range(0, 69)) << 2) | 32'($urandom_range(0, 3));
      run_op($sformatf("rand%0d we%0d f%0d a%h", n, w, f, a), w, f, a, $urandom);
    end

    // Reset during the WRITE cycle of SW 0x24.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("rstmid we before", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_val("rstmid we async", 32'(bus.mem_we), 32'd0);
    @(posedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    m_loads = 0; m_stores = 0; m_errs = 0;
    @(posedge clk); @(negedge clk);
    check_val("rstmid ready", 32'(bus.req_ready), 32'd1);
    check_val("rstmid valid", 32'(bus.resp_valid), 32'd0);
    check_val("rstmid rdata", bus.resp_rdata, 32'd0);
    check_val("rstmid word", mem[9], ref_mem[9]);
    @(posedge clk); #1;

`ifdef LSU_PERF_CNT_EN
    check_val("perf rst loads", 32'(perf_loads), 32'd0);
    for (int i = 0; i < 3; i++) run_op("perf load", 1'b0, 3'd2, 32'(i * 4), 32'd0);
    for (int i = 0; i < 2; i++) run_op("perf store", 1'b1, 3'd2, 32'(i * 4 + 32'h40), $urandom);
    run_op("perf err", 1'b0, 3'd7, 32'h0, 32'd0);
    check_val("perf loads", 32'(perf_loads), 32'(m_loads));
    check_val("perf stores", 32'(perf_stores), 32'(m_stores));
    check_val("perf errors", 32'(perf_errors), 32'(m_errs));
    force dut.perf_loads_r = 16'hFFFF;
    @(posedge clk); #1;
    release dut.perf_loads_r;
    run_op("perf sat load", 1'b0, 3'd2, 32'h0, 32'd0);
    check_val("perf loads sat", 32'(perf_loads), 32'h0000_FFFF);
`endif

    for (int i = 0; i < MEM_WORDS; i++) check_val($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
